// File: rtl/roce_payload_pattern_gen_64.sv
// Test-pattern DMA source for the RoCE TX path: streams L bytes of an
// offset / inverted-offset pattern over 64-bit AXI-Stream, with abort and byte accounting.
module roce_payload_pattern_gen_64 #(
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LENGTH_WIDTH-1:0] s_dma_length,
  input  logic                    s_start,
  input  logic                    s_abort,
  output logic [LENGTH_WIDTH-1:0] m_dma_length,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    busy,
  output logic                    done,
  output logic [LENGTH_WIDTH-1:0] bytes_sent
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(KW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, STREAM = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    start_q, start_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [LENGTH_WIDTH-1:0] off_q, off_d;
  logic [LENGTH_WIDTH-1:0] bytes_q, bytes_d;
  logic                    term_q, term_d;
  logic                    abort_q, abort_d;
  logic                    done_q, done_d;

  logic                    rise, hs, nat_last, beat_last;
  logic [LENGTH_WIDTH:0]   beat_end;
  logic [KW-1:0]           keep_tail, keep_beat;
  logic [PW-1:0]           pop;

  // Beat descriptors are pure functions of the registered offset, so they
  // hold still for as long as the sink stalls.
  always_comb begin
    rise      = s_start & ~start_q;
    hs        = (state_q == STREAM) & m_axis_tready;
    beat_end  = {1'b0, off_q} + (LENGTH_WIDTH+1)'(KW);
    nat_last  = beat_end >= {1'b0, len_q};
    beat_last = nat_last | term_q;
    keep_tail = (len_q[2:0] == 3'd0) ? {KW{1'b1}} : ((KW'(1) << len_q[2:0]) - KW'(1));
    keep_beat = (nat_last && !term_q) ? keep_tail : {KW{1'b1}};
    pop = '0;
    for (int i = 0; i < KW; i++) pop = pop + PW'(keep_beat[i]);
  end

  always_comb begin
    state_d = state_q;
    start_d = s_start;
    len_d   = len_q;
    off_d   = off_q;
    bytes_d = bytes_q;
    term_d  = term_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && s_dma_length != '0) begin
          len_d   = s_dma_length;
          off_d   = '0;
          bytes_d = '0;
          term_d  = 1'b0;
          abort_d = 1'b0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (s_abort) begin
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (s_abort) abort_d = 1'b1;
        if (hs) begin
          off_d   = off_q + LENGTH_WIDTH'(KW);
          bytes_d = bytes_q + LENGTH_WIDTH'(pop);
          if (beat_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
            term_d  = 1'b0;
          end else if (s_abort || abort_q) begin
            // Abort seen by this handshake turns the following beat into the terminator.
            term_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      len_q   <= '0;
      off_q   <= '0;
      bytes_q <= '0;
      term_q  <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      len_q   <= len_d;
      off_q   <= off_d;
      bytes_q <= bytes_d;
      term_q  <= term_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    m_axis_tvalid = (state_q == STREAM);
    m_axis_tdata  = m_axis_tvalid ? DATA_WIDTH'({~off_q, off_q}) : '0;
    m_axis_tkeep  = m_axis_tvalid ? keep_beat : '0;
    m_axis_tlast  = m_axis_tvalid & beat_last;
    m_axis_tuser  = m_axis_tvalid & term_q;
    m_dma_length  = len_q;
    busy          = (state_q != IDLE);
    done          = done_q;
    bytes_sent    = bytes_q;
  end

endmodule

// File: tb/tb_roce_payload_pattern_gen_64.sv
// Scoreboard bench for roce_payload_pattern_gen_64: expected beats are queued
// by the stimulus, a negedge monitor pops and compares on every handshake.
module tb_roce_payload_pattern_gen_64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_dma_length;
  logic        s_start, s_abort;
  logic [31:0] m_dma_length;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic        busy, done;
  logic [31:0] bytes_sent;

  roce_payload_pattern_gen_64 dut (
    .clk(clk), .rst_n(rst_n), .s_dma_length(s_dma_length), .s_start(s_start),
    .s_abort(s_abort), .m_dma_length(m_dma_length), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy), .done(done),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        u;
    logic        l;
    logic [7:0]  k;
    logic [63:0] d;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    passes = 0;
  int    done_cnt = 0;

  task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s actual=%h expected=%h", n, a, e);
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    q.push_back(b);
  endtask

  // Reference beats from the pattern definition; term_idx >= 0 marks the abort terminator.
  task automatic push_model(input int len, input int term_idx);
    int n;
    logic [31:0] off;
    logic [7:0]  k;
    logic        last;
    n = (len + 7) / 8;
    for (int i = 0; i < n; i++) begin
      off = 32'(i * 8);
      if (i == term_idx) begin
        push({~off, off}, 8'hFF, 1'b1, 1'b1);
        return;
      end
      last = (i == n - 1);
      k = (last && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
      push({~off, off}, k, last, 1'b0);
    end
  endtask

  // Monitor: handshakes pop the scoreboard, stalled beats must not change.
  initial begin
    beat_t cur, held;
    bit stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (stall && m_axis_tvalid) chk("stall_stable", 80'(cur), 80'(held));
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat actual=%h expected=none", cur);
        end else begin
          chk("beat", 80'(cur), 80'(q.pop_front()));
        end
      end
      stall = m_axis_tvalid & ~m_axis_tready;
      held  = cur;
    end
  end

  task automatic run_xfer(input int len, input bit rnd, input int abort_off, input int exp_bytes,
                          input bit restart_mid, input bit hold_start);
    int d0, cyc;
    bit got;
    d0 = done_cnt;
    @(posedge clk); #1;
    s_dma_length = len; s_start = 1'b1; m_axis_tready = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("mlen_latch", 80'(m_dma_length), 80'(len));
      if (m_axis_tvalid) begin
        cyc = c;
        break;
      end
    end
    chk("tvalid_latency", 80'(cyc), 80'd2);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      m_axis_tready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (i == 0) s_start = hold_start;
      if (restart_mid && i == 2) s_start = 1'b0;
      if (restart_mid && i == 3) begin
        s_start = 1'b1;
        s_dma_length = 32'd999;
      end
      s_abort = (abort_off >= 0) && m_axis_tvalid && (m_axis_tdata[31:0] == 32'(abort_off));
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    s_abort = 1'b0;
    chk("done_seen", 80'(got), 80'd1);
    chk("bytes_sent", 80'(bytes_sent), 80'(exp_bytes));
    chk("busy_at_done", 80'(busy), 80'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("done_once", 80'(done_cnt - d0), 80'd1);
    chk("mlen_hold", 80'(m_dma_length), 80'(len));
    chk("idle_after", 80'({m_axis_tvalid, busy}), 80'd0);
    s_start = 1'b0;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; s_dma_length = '0; s_start = 1'b0; s_abort = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 80'({m_dma_length, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
                          m_axis_tuser, busy, done, bytes_sent}), 80'd0);
    rst_n = 1'b1;

    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b0, 1'b0);
    push(64'hFFFFFFF7_00000008, 8'hFF, 1'b0, 1'b0);
    push(64'hFFFFFFEF_00000010, 8'h0F, 1'b1, 1'b0);
    run_xfer(20, 1'b0, -1, 20, 1'b0, 1'b0);

    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b0, 1'b0);
    push(64'hFFFFFFF7_00000008, 8'hFF, 1'b1, 1'b0);
    run_xfer(16, 1'b0, -1, 16, 1'b0, 1'b0);

    push(64'hFFFFFFFF_00000000, 8'h01, 1'b1, 1'b0);
    run_xfer(1, 1'b0, -1, 1, 1'b0, 1'b0);

    push_model(200, -1);
    run_xfer(200, 1'b1, -1, 200, 1'b0, 1'b0);

    push_model(64, 3);
    run_xfer(64, 1'b0, 16, 32, 1'b0, 1'b0);

    push_model(48, -1);
    run_xfer(48, 1'b1, -1, 48, 1'b1, 1'b1);

    d0 = done_cnt;
    @(posedge clk); #1;
    s_dma_length = 32'd0; s_start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("zero_len_idle", 80'({busy, m_axis_tvalid}), 80'd0);
    chk("zero_len_mlen", 80'(m_dma_length), 80'd48);
    chk("zero_len_nodone", 80'(done_cnt - d0), 80'd0);
    s_start = 1'b0;

    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    s_dma_length = 32'd40; s_start = 1'b1; m_axis_tready = 1'b1;
    d0 = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_axis_tvalid && m_axis_tdata[31:0] == 32'd8) begin
        d0 = 1;
        break;
      end
    end
    chk("second_beat_seen", 80'(d0), 80'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 80'({m_dma_length, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
                                m_axis_tlast, m_axis_tuser, busy, done, bytes_sent}), 80'd0);
    s_start = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b1, 1'b0);
    run_xfer(8, 1'b0, -1, 8, 1'b0, 1'b0);

    chk("queue_empty", 80'(q.size()), 80'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/roce_payload_pattern_gen_64.md
Name: roce_payload_pattern_gen_64

Overview:
Test-pattern DMA source at the head of the minimal RoCE TX path. On a start edge it latches a transfer length and streams that many bytes as a 64-bit AXI-Stream payload. The stream carries a deterministic offset/inverted-offset pattern. Its outputs feed the payload input and the s_dma_length input of the RoCE TX header producer. It adds a proper backpressure-safe FSM, abort, completion status and byte accounting.

Parameters:
DATA_WIDTH, 64, stream width; only 64 is supported (tkeep 8 bits).
LENGTH_WIDTH, 32, width of the transfer length and byte counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
s_dma_length  in  32  transfer length in bytes, sampled on start edge
s_start  in  1  level; a rising edge requests a transfer
s_abort  in  1  level; terminates the current transfer early
m_dma_length  out  32  latched length; stable for the whole transfer
m_axis_tdata  out  64  payload
m_axis_tkeep  out  8  byte enables
m_axis_tvalid  out  1  AXI-S valid
m_axis_tready  in  1  AXI-S ready
m_axis_tlast  out  1  last beat of the transfer
m_axis_tuser  out  1  1 = aborted transfer (last beat only)
busy  out  1  high in ARM and STREAM
done  out  1  one-cycle pulse after the final beat handshake
bytes_sent  out  32  bytes accepted in the current or most recent transfer

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0, including m_dma_length, bytes_sent and start_d.
- Start detection: start_d <= s_start every cycle. rise = s_start & ~start_d.
- States:
  - IDLE, on rise with s_dma_length != 0: latch L into m_dma_length, clear bytes_sent, clear offset, go to ARM.
  - IDLE, on rise with L == 0: ignored; no beats, no done pulse.
  - Rises in ARM or STREAM are ignored. A held-high s_start never retriggers.
  - ARM: one cycle, so m_dma_length is stable before the first beat. Go to STREAM, or to IDLE if s_abort = 1 (no beats, no done).
  - STREAM: m_axis_tvalid = 1. On the handshake of the last beat, go to IDLE and pulse done the following cycle.
- Latency: rise sampled at edge N gives m_dma_length valid after N+1 and tvalid high after N+2.
- Beat content (offset = byte offset of the beat, starting at 0 and stepping by 8):
  - tdata[31:0] = offset; tdata[63:32] = ~offset.
  - tlast = (offset + 8 >= L), compared at 33 bits so L near 2^32-1 does not wrap.
  - Beat count = ceil(L/8).
- tkeep: 0xFF on non-last beats. On the last beat, 0xFF if L[2:0] == 0, else (1 << L[2:0]) - 1.
- Handshake:
  - Offset advances and bytes_sent += popcount(tkeep) only when tvalid & tready.
  - While tvalid & ~tready, tdata, tkeep, tlast and tuser stay frozen.
- Abort in STREAM: s_abort sets abort_pend.
  - A pending unaccepted beat is not modified.
  - The beat after the next handshake is emitted as a terminator: tlast = 1, tuser = 1, tkeep = 0xFF, normal pattern data. Transfer then ends with done.
  - If the beat accepted when abort arrives is already the natural last beat, completion is normal and tuser stays 0.
  - abort_pend clears on entry to IDLE.
- Simultaneous abort and last-beat handshake: normal completion, tuser = 0.
- tuser is 0 on all other beats.
- done fires exactly once per transfer that reaches STREAM. busy falls in the same cycle done rises.
- Reset mid-transfer: immediate return to IDLE with outputs cleared. A following start behaves as from power-up.

Test Plan:
- L=20, tready=1 -> 3 beats: data 0xFFFFFFFF_00000000, 0xFFFFFFF7_00000008, 0xFFFFFFEF_00000010; last tkeep 0x0F, tlast on beat 3; done once; bytes_sent=20; tvalid 2 cycles after rise.
- L=16 -> 2 beats, last tkeep 0xFF; L=1 -> 1 beat, tkeep 0x01, tlast=1.
- L=200, random tready (~50%) -> data/keep/last stable while stalled, 25 beats in order, bytes_sent=200, busy low after done.
- L=64, assert s_abort after 3rd handshake -> 4th beat has tlast=1, tuser=1, tkeep=0xFF; total 4 beats; done pulse; bytes_sent=32.
- Start edge while STREAM, held-high start, and L=0 start in IDLE -> no extra transfer, m_dma_length unchanged, no done.
- rst_n low during beat 2 of L=40 -> outputs 0 asynchronously; new start with L=8 -> single beat 0xFFFFFFFF_00000000, tkeep 0xFF.
